broadcast_tree: RTL and testbench

- Pipelined fan-out tree: the inverse of the adder reduction. Takes one LANES-wide vector with a destination mask and replicates it to FANOUT destinations through a registered ARITY-ary tree.
- Used to distribute operand vectors (e.g. from the vector register file) to many dot-product tiles without long, high-fanout nets.
- Each destination gets its own valid, gated by the mask.

---
 rtl/broadcast_tree.sv | 108 ++++++++++
 tb/tb_broadcast_tree.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/broadcast_tree.sv
// Pipelined ARITY-ary fan-out tree: replicates one LANES-wide vector to FANOUT
// destinations through registered levels, each node gated by its subtree mask.
module broadcast_tree #(
  parameter int unsigned DATAW  = 18,
  parameter int unsigned LANES  = 1,
  parameter int unsigned FANOUT = 40,
  parameter int unsigned ARITY  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [DATAW-1:0] i_data      [LANES],
  input  logic [FANOUT-1:0]       i_dest_mask,
  input  logic                    i_valid,
  output logic signed [DATAW-1:0] o_data      [FANOUT][LANES],
  output logic [FANOUT-1:0]       o_valid,
  output logic                    o_busy
);

  function automatic int unsigned ipow(input int unsigned b, input int unsigned e);
    int unsigned r;
    r = 1;
    for (int unsigned k = 0; k < e; k++) r = r * b;
    return r;
  endfunction

  function automatic int unsigned clog_arity(input int unsigned n, input int unsigned a);
    int unsigned lv;
    int unsigned s;
    lv = 0;
    s  = 1;
    while (s < n) begin
      s  = s * a;
      lv = lv + 1;
    end
    return lv;
  endfunction

  localparam int unsigned LEVELS = clog_arity(FANOUT, ARITY);

  logic [LEVELS:0] lvl_any_d;
  logic            busy_q;

  for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
    // SPAN = leaves covered by one node at this level
    localparam int unsigned SPAN  = ipow(ARITY, LEVELS - l);
    localparam int unsigned NODES = (FANOUT + SPAN - 1) / SPAN;

    logic [NODES-1:0] valid_d;
    logic [NODES-1:0] valid_q;

    always_ff @(posedge clk) begin
      if (rst) valid_q <= '0;
      else     valid_q <= valid_d;
    end

    assign lvl_any_d[l] = |valid_d;

    for (genvar j = 0; j < NODES; j++) begin : g_node
      localparam int unsigned LO = j * SPAN;
      localparam int unsigned HI = (((j + 1) * SPAN < FANOUT) ? (j + 1) * SPAN : FANOUT) - 1;

      logic                    par_valid_c;
      logic [HI-LO:0]          src_mask_c;
      logic signed [DATAW-1:0] src_data_c [LANES];
      logic signed [DATAW-1:0] data_q     [LANES];

      if (l == 0) begin : g_src
        assign par_valid_c = i_valid;
        assign src_mask_c  = i_dest_mask;
        assign src_data_c  = i_data;
      end else begin : g_src
        // Parent holds only its own leaf range; re-base our range into it
        localparam int unsigned P   = j / ARITY;
        localparam int unsigned PLO = P * SPAN * ARITY;
        assign par_valid_c = g_lvl[l-1].valid_q[P];
        assign src_mask_c  = g_lvl[l-1].g_node[P].g_m.mask_q[HI-PLO:LO-PLO];
        assign src_data_c  = g_lvl[l-1].g_node[P].data_q;
      end

      assign valid_d[j] = par_valid_c & (|src_mask_c);

      always_ff @(posedge clk) begin
        if (valid_d[j]) data_q <= src_data_c;
      end

      if (l < LEVELS) begin : g_m
        logic [HI-LO:0] mask_q;
        always_ff @(posedge clk) begin
          if (valid_d[j]) mask_q <= src_mask_c;
        end
      end
    end
  end

  // Busy tracks the next node valids so it lines up with valid_q
  always_ff @(posedge clk) begin
    if (rst) busy_q <= 1'b0;
    else     busy_q <= |lvl_any_d;
  end

  for (genvar d = 0; d < FANOUT; d++) begin : g_out
    assign o_data[d] = g_lvl[LEVELS].g_node[d].data_q;
  end

  assign o_valid = g_lvl[LEVELS].valid_q;
  assign o_busy  = busy_q;

endmodule

// File: tb/tb_broadcast_tree.sv
// Directed bench for broadcast_tree across four configurations sharing clk/rst.
module tb_broadcast_tree;

  localparam int unsigned DW = 18;
  localparam logic [39:0] ALL40 = '1;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // default configuration
  logic signed [DW-1:0] d_in   [1];
  logic [39:0]          d_mask;
  logic                 d_valid;
  logic signed [DW-1:0] d_out  [40][1];
  logic [39:0]          d_ov;
  logic                 d_busy;

  // LANES=4
  logic signed [DW-1:0] l_in   [4];
  logic [39:0]          l_mask;
  logic                 l_valid;
  logic signed [DW-1:0] l_out  [40][4];
  logic [39:0]          l_ov;
  logic                 l_busy;

  // FANOUT=1
  logic signed [DW-1:0] s_in   [1];
  logic [0:0]           s_mask;
  logic                 s_valid;
  logic signed [DW-1:0] s_out  [1][1];
  logic [0:0]           s_ov;
  logic                 s_busy;

  // FANOUT=5, ARITY=3, LANES=2
  logic signed [DW-1:0] f_in   [2];
  logic [4:0]           f_mask;
  logic                 f_valid;
  logic signed [DW-1:0] f_out  [5][2];
  logic [4:0]           f_ov;
  logic                 f_busy;

  broadcast_tree #(.DATAW(DW), .LANES(1), .FANOUT(40), .ARITY(2)) u_def (
    .clk(clk), .rst(rst), .i_data(d_in), .i_dest_mask(d_mask), .i_valid(d_valid),
    .o_data(d_out), .o_valid(d_ov), .o_busy(d_busy));

  broadcast_tree #(.DATAW(DW), .LANES(4), .FANOUT(40), .ARITY(2)) u_l4 (
    .clk(clk), .rst(rst), .i_data(l_in), .i_dest_mask(l_mask), .i_valid(l_valid),
    .o_data(l_out), .o_valid(l_ov), .o_busy(l_busy));

  broadcast_tree #(.DATAW(DW), .LANES(1), .FANOUT(1), .ARITY(2)) u_f1 (
    .clk(clk), .rst(rst), .i_data(s_in), .i_dest_mask(s_mask), .i_valid(s_valid),
    .o_data(s_out), .o_valid(s_ov), .o_busy(s_busy));

  broadcast_tree #(.DATAW(DW), .LANES(2), .FANOUT(5), .ARITY(3)) u_f5 (
    .clk(clk), .rst(rst), .i_data(f_in), .i_dest_mask(f_mask), .i_valid(f_valid),
    .o_data(f_out), .o_valid(f_ov), .o_busy(f_busy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] sm [20];
    int          expd  [40];
    bit          known [40];
    logic [39:0] expv;
    bit          ok;
    int          idx;

    rst = 1'b1;
    d_in[0] = '0; d_mask = '0; d_valid = 1'b0;
    for (int k = 0; k < 4; k++) l_in[k] = '0;
    l_mask = '0; l_valid = 1'b0;
    s_in[0] = '0; s_mask = '0; s_valid = 1'b0;
    f_in[0] = '0; f_in[1] = '0; f_mask = '0; f_valid = 1'b0;
    tick();
    tick();
    chk("rst_def_valid", d_ov, 0);
    chk("rst_def_busy", d_busy, 0);
    chk("rst_l4_valid", l_ov, 0);
    chk("rst_f1_valid", s_ov, 0);
    chk("rst_f5_valid", f_ov, 0);
    chk("rst_f5_busy", f_busy, 0);
    rst = 1'b0;

    // single broadcast to all 40 destinations
    d_in[0] = -18'sd5; d_mask = ALL40; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    chk("t1_busy_c1", d_busy, 1);
    chk("t1_valid_c1", d_ov, 0);
    for (int c = 2; c <= 7; c++) begin
      tick();
      chk("t1_busy", d_busy, 1);
      if (c < 7) chk("t1_valid_early", d_ov, 0);
    end
    chk("t1_valid_c7", d_ov, ALL40);
    for (int d = 0; d < 40; d++) chk("t1_data", d_out[d][0], -5);
    tick();
    chk("t1_valid_c8", d_ov, 0);
    chk("t1_busy_c8", d_busy, 0);
    chk("t1_hold", d_out[17][0], -5);

    // first and last destination on consecutive cycles
    d_in[0] = 18'sd100; d_mask = 40'h1; d_valid = 1'b1;
    tick();
    d_in[0] = 18'sd200; d_mask = 40'h80_0000_0000;
    tick();
    d_valid = 1'b0; d_mask = '0;
    for (int c = 3; c <= 7; c++) begin
      tick();
      if (c < 7) chk("t2_valid_early", d_ov, 0);
    end
    chk("t2_valid_c7", d_ov, 40'h1);
    chk("t2_d0_c7", d_out[0][0], 100);
    chk("t2_d39_c7", d_out[39][0], -5);
    tick();
    chk("t2_valid_c8", d_ov, 40'h80_0000_0000);
    chk("t2_d39_c8", d_out[39][0], 200);
    chk("t2_d0_hold", d_out[0][0], 100);

    // all-zero mask is dropped at the root
    d_in[0] = 18'sd9; d_mask = '0; d_valid = 1'b1;
    tick();
    d_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      chk("t3_valid", d_ov, 0);
      chk("t3_busy", d_busy, 0);
      tick();
    end

    // reset while three vectors are in flight, plus one in the reset cycle
    d_mask = ALL40; d_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      d_in[0] = 18'(k);
      tick();
    end
    d_in[0] = 18'sd4; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t4_valid_after_rst", d_ov, 0);
    chk("t4_busy_after_rst", d_busy, 0);
    d_in[0] = 18'sd77;
    tick();
    d_valid = 1'b0;
    chk("t4_busy_c1", d_busy, 1);
    for (int c = 2; c <= 7; c++) begin
      tick();
      if (c < 7) chk("t4_valid_early", d_ov, 0);
    end
    chk("t4_valid_c7", d_ov, ALL40);
    chk("t4_d0", d_out[0][0], 77);
    chk("t4_d39", d_out[39][0], 77);
    tick();
    chk("t4_valid_c8", d_ov, 0);
    chk("t4_busy_c8", d_busy, 0);

    // 20 back-to-back vectors, LANES=4, random masks
    for (int i = 0; i < 20; i++) sm[i] = 40'({$urandom(), $urandom()});
    sm[5]  = '0;
    sm[10] = ALL40;
    for (int d = 0; d < 40; d++) begin
      known[d] = 1'b0;
      expd[d]  = 0;
    end
    for (int t = 0; t < 28; t++) begin
      if (t < 20) begin
        for (int k = 0; k < 4; k++) l_in[k] = 18'(t);
        l_mask  = sm[t];
        l_valid = 1'b1;
      end else begin
        l_valid = 1'b0;
        l_mask  = '0;
      end
      tick();
      idx  = t - 6;
      expv = '0;
      if (idx >= 0 && idx < 20) begin
        expv = sm[idx];
        for (int d = 0; d < 40; d++) begin
          if (expv[d]) begin
            known[d] = 1'b1;
            expd[d]  = idx;
          end
        end
      end
      chk("stream_valid", l_ov, expv);
      ok = 1'b1;
      for (int d = 0; d < 40; d++)
        for (int k = 0; k < 4; k++)
          if (known[d] && (l_out[d][k] !== 18'(expd[d]))) ok = 1'b0;
      chk("stream_data", ok, 1);
    end
    chk("stream_busy_end", l_busy, 0);

    // FANOUT=1: single register, latency 1
    s_in[0] = 18'sd7; s_mask = 1'b1; s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk("f1_valid", s_ov, 1);
    chk("f1_data", s_out[0][0], 7);
    chk("f1_busy", s_busy, 1);
    tick();
    chk("f1_valid_off", s_ov, 0);
    chk("f1_busy_off", s_busy, 0);
    chk("f1_hold", s_out[0][0], 7);

    // FANOUT=5, ARITY=3: uneven last parent, DATAW extremes
    f_in[0] = 18'sd131071; f_in[1] = -18'sd131072; f_mask = 5'b10101; f_valid = 1'b1;
    tick();
    f_valid = 1'b0;
    chk("f5_valid_c1", f_ov, 0);
    chk("f5_busy_c1", f_busy, 1);
    tick();
    chk("f5_valid_c2", f_ov, 0);
    tick();
    chk("f5_valid_c3", f_ov, 5'b10101);
    for (int d = 0; d < 5; d += 2) begin
      chk("f5_lane0", f_out[d][0], 131071);
      chk("f5_lane1", f_out[d][1], -131072);
    end
    tick();
    chk("f5_valid_c4", f_ov, 0);
    chk("f5_busy_c4", f_busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
